gshare_btb_predictor: RTL and testbench
=======================================

# gshare_btb_predictor

Next-generation front-end branch predictor for the PC stage. It predicts the next fetch PC for a block of NUM_FETCH instructions using a gshare pattern history table (PC XOR global history) and a fully-associative BTB with round-robin replacement. It keeps a speculative global history that is repaired on mispredict, and exposes mispredict statistics. It sits between the PC register and instruction memory, and is updated by the branch unit.

## Interface
- BW_ADDRESS, 32, PC width (byte address, bits [1:0] always 0)
- NUM_FETCH, 2, instructions per fetch block (power of 2, ≥1)
- BW_PC_MOD, max(clog2(NUM_FETCH),1), slot index width
- NUM_GLOBAL_HISTORY, 4, global history bits (≤ BW_PHT_INDEX)
- BW_PHT_INDEX, 6, PHT index width; PHT has 2^BW_PHT_INDEX 2-bit counters
- NUM_BTB, 8, BTB entries
- BW_STAT, 16, statistics counter width
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- i_fetch_pc  in  BW_ADDRESS  current fetch PC
- i_fetch_accept  in  1  fetch block consumed this cycle; commits speculative history
- o_predicted_pc  out  BW_ADDRESS  next fetch PC
- o_pc_upperbound  out  BW_PC_MOD  last valid slot in block (taken slot, or all-ones)
- o_predicted_taken  out  1  some valid slot predicted taken
- o_global_history  out  NUM_GLOBAL_HISTORY  speculative history used for this lookup
- i_branch_valid  in  1  resolved branch
- i_branch_pc  in  BW_ADDRESS  branch PC
- i_branch_target  in  BW_ADDRESS  actual next PC
- i_branch_taken  in  1  actual direction
- i_branch_global_history  in  NUM_GLOBAL_HISTORY  history carried from prediction
- i_branch_mispredict  in  1  pipeline flushed due to this branch
- o_stat_resolved, o_stat_mispredict  out  BW_STAT  saturating counts

## Operation
- Word PC w = pc>>2. Slot i address = {w[high:BW_PC_MOD], 0} + i; slot valid iff i ≥ i_fetch_pc[BW_PC_MOD+1:2].
- PHT index(w, h) = w[BW_PHT_INDEX-1:0] XOR zero-extended h. Prediction uses the speculative history spec_hist; update uses i_branch_global_history.
- Counter: 0 strong-NT, 1 weak-NT, 2 weak-T, 3 strong-T; taken iff ≥2; saturating ±1 toward outcome.
- BTB lookup per slot: hit iff valid && tag == slot word address (full BW_ADDRESS-2 tag). Slot predicted taken iff hit && counter taken.
- Select the lowest valid taken slot: o_predicted_pc = its BTB target, o_pc_upperbound = its index, o_predicted_taken = 1. If no slot is taken: o_predicted_pc = block base + NUM_FETCH*4, upperbound = all-ones, taken = 0.
- Speculative history on i_fetch_accept: if any valid BTB-hit slot at or below the selected slot, shift in o_predicted_taken (one bit per block). Otherwise unchanged.
- Resolve (i_branch_valid): update the PHT counter at index(i_branch_pc, i_branch_global_history). Stats: resolved+1, and mispredict+1 if i_branch_mispredict; both saturate at all-ones.
- BTB update, taken only: on hit, overwrite target. On miss, insert at the lowest invalid entry; if all are valid, insert at rr_ptr, then rr_ptr = (rr_ptr+1) mod NUM_BTB. Not-taken resolves never modify the BTB.
- Mispredict repair: spec_hist ← {i_branch_global_history[N-2:0], i_branch_taken}. This takes priority over a same-cycle fetch-accept shift.

## Timing
- Prediction outputs are combinational from i_fetch_pc and registered state. Zero-cycle lookup.
- All updates land at the next posedge. A same-cycle lookup sees pre-update state.
- Reset (any cycle, including mid-operation) clears spec_hist, all BTB valid bits, rr_ptr, and stats to 0. PHT counters reset to 1 (weak-NT). In the cycle after reset: o_predicted_pc = block base + NUM_FETCH*4, o_predicted_taken = 0, o_global_history = 0, stats = 0.
- One resolve per cycle; no backpressure on either port.

## Structure
- Package bp_pkg: counter localparams (STRONGLY_NOT_TAKEN..STRONGLY_TAKEN), PHT_RESET_VALUE, function counter_next(cnt, taken).
- Sub-module branch_target_buffer: CAM lookup for NUM_FETCH ports, one update port, invalid-first/round-robin insertion. Reuse FindFirstOneFromLsb for both slot selection and free-entry search.

## Test plan
- Reset, then i_fetch_pc=0x100, NUM_FETCH=2 -> o_predicted_pc=0x108, upperbound=1, taken=0, history=0.
- Resolve 0x104 taken→0x200 twice with history 0, then fetch 0x100 -> predicted 0x200, upperbound=1, taken=1. Fetch 0x104 -> slot 0 invalid, same prediction.
- Fill 8 BTB entries with taken branches, then insert a 9th -> entry 0 replaced; a 10th -> entry 1 replaced. Old PC at entry 0 now misses.
- With 0x100 trained taken, accept 3 fetches -> history 0b0111. Then mispredict with i_branch_global_history=0b0010, taken=0, while also accepting a fetch -> history 0b0100.
- Resolve the same PC not-taken 4 times from counter 3 -> counter 0, and its BTB entry is still valid.
- Drive 2^16+5 mispredicting resolves -> both stats hold at 0xFFFF. Assert rst mid-stream -> stats 0 next cycle.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared constants and helpers for the gshare/BTB front-end predictor.
package bp_pkg;

    localparam int BW_ADDRESS         = 32;
    localparam int NUM_FETCH          = 2;
    localparam int BW_PC_MOD          = ($clog2(NUM_FETCH) > 1) ? $clog2(NUM_FETCH) : 1;
    localparam int NUM_GLOBAL_HISTORY = 4;
    localparam int BW_PHT_INDEX       = 6;
    localparam int NUM_BTB            = 8;
    localparam int BW_STAT            = 16;

    // Word address width: the two byte-offset bits are always zero.
    localparam int BW_TAG     = BW_ADDRESS - 2;
    localparam int BW_BTB_IDX = (NUM_BTB > 1) ? $clog2(NUM_BTB) : 1;

    // Two-bit saturating direction counter encoding.
    localparam logic [1:0] STRONGLY_NOT_TAKEN = 2'd0;
    localparam logic [1:0] WEAKLY_NOT_TAKEN   = 2'd1;
    localparam logic [1:0] WEAKLY_TAKEN       = 2'd2;
    localparam logic [1:0] STRONGLY_TAKEN     = 2'd3;
    localparam logic [1:0] PHT_RESET_VALUE    = WEAKLY_NOT_TAKEN;

    // Move the counter one step toward the observed outcome, saturating at both ends.
    function automatic logic [1:0] counter_next(input logic [1:0] cnt, input logic taken);
        logic [1:0] nxt;
        nxt = cnt;
        if (taken && (cnt != STRONGLY_TAKEN)) begin
            nxt = cnt + 2'd1;
        end else if (!taken && (cnt != STRONGLY_NOT_TAKEN)) begin
            nxt = cnt - 2'd1;
        end
        return nxt;
    endfunction

    // gshare index: low word-address bits XOR zero-extended global history.
    function automatic logic [BW_PHT_INDEX-1:0] pht_index(
        input logic [BW_PHT_INDEX-1:0]       word_low,
        input logic [NUM_GLOBAL_HISTORY-1:0] hist
    );
        return word_low ^ BW_PHT_INDEX'(hist);
    endfunction

endpackage

// File: rtl/gshare_btb_predictor_if.sv
// Fetch-side lookup and branch-unit resolve signals of the predictor.
//
// Handshake: there is no backpressure on either side. i_fetch_accept marks
// that the block looked up at i_fetch_pc is consumed this cycle.
// i_branch_valid qualifies all i_branch_* fields for exactly that cycle;
// at most one resolve per cycle. Prediction outputs are combinational.
interface gshare_btb_predictor_if;
    import bp_pkg::*;

    logic [BW_ADDRESS-1:0]         i_fetch_pc;
    logic                          i_fetch_accept;
    logic [BW_ADDRESS-1:0]         o_predicted_pc;
    logic [BW_PC_MOD-1:0]          o_pc_upperbound;
    logic                          o_predicted_taken;
    logic [NUM_GLOBAL_HISTORY-1:0] o_global_history;

    logic                          i_branch_valid;
    logic [BW_ADDRESS-1:0]         i_branch_pc;
    logic [BW_ADDRESS-1:0]         i_branch_target;
    logic                          i_branch_taken;
    logic [NUM_GLOBAL_HISTORY-1:0] i_branch_global_history;
    logic                          i_branch_mispredict;

    logic [BW_STAT-1:0]            o_stat_resolved;
    logic [BW_STAT-1:0]            o_stat_mispredict;

    modport master (
        output i_fetch_pc, i_fetch_accept,
        output i_branch_valid, i_branch_pc, i_branch_target, i_branch_taken,
        output i_branch_global_history, i_branch_mispredict,
        input  o_predicted_pc, o_pc_upperbound, o_predicted_taken, o_global_history,
        input  o_stat_resolved, o_stat_mispredict
    );

    modport slave (
        input  i_fetch_pc, i_fetch_accept,
        input  i_branch_valid, i_branch_pc, i_branch_target, i_branch_taken,
        input  i_branch_global_history, i_branch_mispredict,
        output o_predicted_pc, o_pc_upperbound, o_predicted_taken, o_global_history,
        output o_stat_resolved, o_stat_mispredict
    );

endinterface

// File: rtl/gshare_btb_predictor_btb.sv
// Priority encoder plus fully-associative branch target buffer with
// invalid-first, then round-robin, insertion.

module find_first_one_from_lsb #(
    parameter int WIDTH    = 8,
    parameter int BW_INDEX = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0]    vec_i,
    output logic                found_o,
    output logic [BW_INDEX-1:0] index_o
);
    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        found_o = 1'b0;
        index_o = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                found_o = 1'b1;
                index_o = BW_INDEX'(i);
            end
        end
    end
endmodule

module branch_target_buffer
    import bp_pkg::*;
(
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_FETCH-1:0][BW_TAG-1:0]     lookup_tag_i,
    output logic [NUM_FETCH-1:0]                 lookup_hit_o,
    output logic [NUM_FETCH-1:0][BW_ADDRESS-1:0] lookup_target_o,
    input  logic                                 update_valid_i,
    input  logic [BW_TAG-1:0]                    update_tag_i,
    input  logic [BW_ADDRESS-1:0]                update_target_i
);
    logic [NUM_BTB-1:0]                 valid_q;
    logic [BW_TAG-1:0]                  tag_q    [NUM_BTB];
    logic [BW_ADDRESS-1:0]              target_q [NUM_BTB];
    logic [BW_BTB_IDX-1:0]              rr_ptr_q, rr_ptr_d;

    logic [NUM_FETCH-1:0][NUM_BTB-1:0]  lookup_match;
    logic [NUM_BTB-1:0]                 update_match;
    logic [NUM_BTB-1:0]                 free_vec;
    logic                               update_hit, free_found;
    logic [BW_BTB_IDX-1:0]              update_hit_idx, free_idx, wr_idx;

    // CAM compare of every lookup port and the update port against all entries.
    always_comb begin
        for (int e = 0; e < NUM_BTB; e++) begin
            for (int s = 0; s < NUM_FETCH; s++) begin
                lookup_match[s][e] = valid_q[e] && (tag_q[e] == lookup_tag_i[s]);
            end
            update_match[e] = valid_q[e] && (tag_q[e] == update_tag_i);
        end
        free_vec = ~valid_q;
    end

    for (genvar s = 0; s < NUM_FETCH; s++) begin : g_lookup
        logic [BW_BTB_IDX-1:0] hit_idx;
        find_first_one_from_lsb #(.WIDTH(NUM_BTB), .BW_INDEX(BW_BTB_IDX)) u_hit (
            .vec_i   (lookup_match[s]),
            .found_o (lookup_hit_o[s]),
            .index_o (hit_idx)
        );
        assign lookup_target_o[s] = target_q[hit_idx];
    end

    find_first_one_from_lsb #(.WIDTH(NUM_BTB), .BW_INDEX(BW_BTB_IDX)) u_update_hit (
        .vec_i   (update_match),
        .found_o (update_hit),
        .index_o (update_hit_idx)
    );

    find_first_one_from_lsb #(.WIDTH(NUM_BTB), .BW_INDEX(BW_BTB_IDX)) u_free (
        .vec_i   (free_vec),
        .found_o (free_found),
        .index_o (free_idx)
    );

    // Write slot: existing entry, else lowest free, else round-robin victim.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        wr_idx   = rr_ptr_q;
        if (update_hit) begin
            wr_idx = update_hit_idx;
        end else if (free_found) begin
            wr_idx = free_idx;
        end else if (update_valid_i) begin
            rr_ptr_d = (rr_ptr_q == BW_BTB_IDX'(NUM_BTB - 1)) ? '0 : rr_ptr_q + BW_BTB_IDX'(1);
        end
    end

    // Valid bits and replacement pointer; cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            if (update_valid_i) begin
                valid_q[wr_idx] <= 1'b1;
            end
        end
    end

    // Tag/target payload; meaningless while the valid bit is clear.
    always_ff @(posedge clk) begin
        if (update_valid_i) begin
            tag_q[wr_idx]    <= update_tag_i;
            target_q[wr_idx] <= update_target_i;
        end
    end
endmodule

// File: rtl/gshare_btb_predictor.sv
// Fetch-block next-PC predictor: gshare direction table plus BTB targets,
// speculative global history with mispredict repair, resolve statistics.
module gshare_btb_predictor
    import bp_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    gshare_btb_predictor_if.slave bus
);
    localparam int N_HIST   = NUM_GLOBAL_HISTORY;
    localparam int PHT_SIZE = 1 << BW_PHT_INDEX;

    logic [1:0]                           pht_q [PHT_SIZE];
    logic [N_HIST-1:0]                    spec_hist_q, spec_hist_d;
    logic [BW_STAT-1:0]                   stat_resolved_q, stat_resolved_d;
    logic [BW_STAT-1:0]                   stat_mispredict_q, stat_mispredict_d;

    logic [BW_TAG-1:0]                    fetch_word, base_word, branch_word;
    logic [BW_PC_MOD-1:0]                 start_slot;
    logic [NUM_FETCH-1:0][BW_TAG-1:0]     slot_tag;
    logic [NUM_FETCH-1:0]                 slot_valid, slot_hit, slot_taken;
    logic [NUM_FETCH-1:0][BW_ADDRESS-1:0] slot_target;
    logic                                 sel_found;
    logic [BW_PC_MOD-1:0]                 sel_idx, upperbound;
    logic [BW_ADDRESS-1:0]                pred_pc;
    logic                                 hit_at_or_below;
    logic [BW_PHT_INDEX-1:0]              update_idx;
    logic                                 unused_offset_bits;

    assign fetch_word  = bus.i_fetch_pc[BW_ADDRESS-1:2];
    assign base_word   = {fetch_word[BW_TAG-1:BW_PC_MOD], {BW_PC_MOD{1'b0}}};
    assign start_slot  = fetch_word[BW_PC_MOD-1:0];
    assign branch_word = bus.i_branch_pc[BW_ADDRESS-1:2];
    assign update_idx  = pht_index(branch_word[BW_PHT_INDEX-1:0], bus.i_branch_global_history);
    assign unused_offset_bits = ^{bus.i_fetch_pc[1:0], bus.i_branch_pc[1:0]};

    // Per-slot address, validity and taken decision from the speculative history.
    always_comb begin
        for (int i = 0; i < NUM_FETCH; i++) begin
            slot_tag[i]   = base_word + BW_TAG'(i);
            slot_valid[i] = (BW_PC_MOD'(i) >= start_slot);
            slot_taken[i] = slot_valid[i] && slot_hit[i]
                && pht_q[pht_index(slot_tag[i][BW_PHT_INDEX-1:0], spec_hist_q)][1];
        end
    end

    branch_target_buffer u_btb (
        .clk             (clk),
        .rst             (rst),
        .lookup_tag_i    (slot_tag),
        .lookup_hit_o    (slot_hit),
        .lookup_target_o (slot_target),
        .update_valid_i  (bus.i_branch_valid && bus.i_branch_taken),
        .update_tag_i    (branch_word),
        .update_target_i (bus.i_branch_target)
    );

    find_first_one_from_lsb #(.WIDTH(NUM_FETCH), .BW_INDEX(BW_PC_MOD)) u_slot_select (
        .vec_i   (slot_taken),
        .found_o (sel_found),
        .index_o (sel_idx)
    );

    // Next PC: first taken slot's target, otherwise the sequential next block.
    always_comb begin
        if (sel_found) begin
            pred_pc    = slot_target[sel_idx];
            upperbound = sel_idx;
        end else begin
            pred_pc    = {base_word, 2'b00} + BW_ADDRESS'(NUM_FETCH * 4);
            upperbound = '1;
        end
        hit_at_or_below = 1'b0;
        for (int i = 0; i < NUM_FETCH; i++) begin
            if (slot_valid[i] && slot_hit[i] && (BW_PC_MOD'(i) <= upperbound)) begin
                hit_at_or_below = 1'b1;
            end
        end
    end

    assign bus.o_predicted_pc    = pred_pc;
    assign bus.o_pc_upperbound   = upperbound;
    assign bus.o_predicted_taken = sel_found;
    assign bus.o_global_history  = spec_hist_q;
    assign bus.o_stat_resolved   = stat_resolved_q;
    assign bus.o_stat_mispredict = stat_mispredict_q;

    // History repair wins over the accept shift; stats saturate at all-ones.
    always_comb begin
        spec_hist_d       = spec_hist_q;
        stat_resolved_d   = stat_resolved_q;
        stat_mispredict_d = stat_mispredict_q;
        if (bus.i_branch_valid && bus.i_branch_mispredict) begin
            spec_hist_d = {bus.i_branch_global_history[N_HIST-2:0], bus.i_branch_taken};
        end else if (bus.i_fetch_accept && hit_at_or_below) begin
            spec_hist_d = {spec_hist_q[N_HIST-2:0], sel_found};
        end
        if (bus.i_branch_valid) begin
            if (!(&stat_resolved_q)) begin
                stat_resolved_d = stat_resolved_q + BW_STAT'(1);
            end
            if (bus.i_branch_mispredict && !(&stat_mispredict_q)) begin
                stat_mispredict_d = stat_mispredict_q + BW_STAT'(1);
            end
        end
    end

    // History and statistics registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            spec_hist_q       <= '0;
            stat_resolved_q   <= '0;
            stat_mispredict_q <= '0;
        end else begin
            spec_hist_q       <= spec_hist_d;
            stat_resolved_q   <= stat_resolved_d;
            stat_mispredict_q <= stat_mispredict_d;
        end
    end

    // Pattern history table: trained with the history carried by the branch.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < PHT_SIZE; k++) begin
                pht_q[k] <= PHT_RESET_VALUE;
            end
        end else if (bus.i_branch_valid) begin
            pht_q[update_idx] <= counter_next(pht_q[update_idx], bus.i_branch_taken);
        end
    end
endmodule

// File: tb/tb_gshare_btb_predictor.sv
// Directed bench for gshare_btb_predictor with an expected-value queue
// drained by a negedge monitor.
module tb_gshare_btb_predictor;
    import bp_pkg::*;

    typedef struct packed {
        logic [31:0]          pc;
        logic [BW_PC_MOD-1:0] ub;
        logic                 taken;
        logic [3:0]           hist;
        logic [15:0]          res;
        logic [15:0]          mis;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   passed = 0;
    int   model_res = 0;
    int   model_mis = 0;

    gshare_btb_predictor_if bus();

    gshare_btb_predictor dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not finish, pending=%0d", exp_q.size());
        $fatal(1, "timeout");
    end

    task automatic check_val(input string name, input string field,
                             input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s.%s: got 0x%0h expected 0x%0h", name, field, act, exp);
    endtask

    // Monitor: outputs are combinational, so compare mid-cycle on negedge.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t  e;
            string n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            check_val(n, "pc",    bus.o_predicted_pc,              e.pc);
            check_val(n, "ub",    32'(bus.o_pc_upperbound),        32'(e.ub));
            check_val(n, "taken", 32'(bus.o_predicted_taken),      32'(e.taken));
            check_val(n, "hist",  32'(bus.o_global_history),       32'(e.hist));
            check_val(n, "res",   32'(bus.o_stat_resolved),        32'(e.res));
            check_val(n, "mis",   32'(bus.o_stat_mispredict),      32'(e.mis));
        end
    end

    // Advance one cycle; the stat model follows what was driven in the old cycle.
    task automatic step();
        @(posedge clk);
        if (rst) begin
            model_res = 0;
            model_mis = 0;
        end else if (bus.i_branch_valid) begin
            if (model_res < 65535) model_res++;
            if (bus.i_branch_mispredict && model_mis < 65535) model_mis++;
        end
        #1;
        rst                     = 1'b0;
        bus.i_fetch_accept      = 1'b0;
        bus.i_branch_valid      = 1'b0;
        bus.i_branch_taken      = 1'b0;
        bus.i_branch_mispredict = 1'b0;
    endtask

    task automatic reset_dut();
        step();
        rst = 1'b1;
        step();
    endtask

    task automatic fetch(input logic [31:0] pc, input logic accept);
        bus.i_fetch_pc     = pc;
        bus.i_fetch_accept = accept;
    endtask

    task automatic resolve(input logic [31:0] pc, input logic [31:0] target,
                           input logic taken, input logic [3:0] gh, input logic mis);
        bus.i_branch_valid          = 1'b1;
        bus.i_branch_pc             = pc;
        bus.i_branch_target         = target;
        bus.i_branch_taken          = taken;
        bus.i_branch_global_history = gh;
        bus.i_branch_mispredict     = mis;
    endtask

    task automatic expect_pred(input string name, input logic [31:0] pc,
                               input logic [BW_PC_MOD-1:0] ub, input logic taken,
                               input logic [3:0] hist);
        exp_t e;
        e.pc    = pc;
        e.ub    = ub;
        e.taken = taken;
        e.hist  = hist;
        e.res   = 16'(model_res);
        e.mis   = 16'(model_mis);
        exp_q.push_back(e);
        name_q.push_back(name);
    endtask

    initial begin
        rst                         = 1'b1;
        bus.i_fetch_pc              = 32'h0;
        bus.i_fetch_accept          = 1'b0;
        bus.i_branch_valid          = 1'b0;
        bus.i_branch_pc             = 32'h0;
        bus.i_branch_target         = 32'h0;
        bus.i_branch_taken          = 1'b0;
        bus.i_branch_global_history = 4'h0;
        bus.i_branch_mispredict     = 1'b0;
        step();

        // Reset state and first lookup
        reset_dut();
        fetch(32'h100, 1'b0);
        expect_pred("reset_pred", 32'h108, 1'b1, 1'b0, 4'h0);

        // Train slot 1 of block 0x100, then a slot 0 branch
        step(); resolve(32'h104, 32'h200, 1'b1, 4'h0, 1'b0);
        expect_pred("pre_update", 32'h108, 1'b1, 1'b0, 4'h0);
        step(); resolve(32'h104, 32'h200, 1'b1, 4'h0, 1'b0);
        step(); fetch(32'h100, 1'b0);
        expect_pred("trained_blk", 32'h200, 1'b1, 1'b1, 4'h0);
        step(); fetch(32'h104, 1'b0);
        expect_pred("slot0_invalid", 32'h200, 1'b1, 1'b1, 4'h0);
        step(); fetch(32'h108, 1'b0);
        expect_pred("next_blk_miss", 32'h110, 1'b1, 1'b0, 4'h0);
        resolve(32'h100, 32'h300, 1'b1, 4'h0, 1'b0);
        step(); fetch(32'h100, 1'b0);
        expect_pred("lowest_slot", 32'h300, 1'b0, 1'b1, 4'h0);
        step(); fetch(32'h104, 1'b0);
        expect_pred("slot0_skipped", 32'h200, 1'b1, 1'b1, 4'h0);

        // BTB fill and round-robin replacement
        reset_dut();
        for (int k = 0; k < 8; k++) begin
            resolve(32'h1000 + 32'(16 * k), 32'h2000 + 32'(16 * k), 1'b1, 4'h0, 1'b0);
            step();
        end
        fetch(32'h1000, 1'b0);
        expect_pred("btb_full_e0", 32'h2000, 1'b0, 1'b1, 4'h0);
        step(); fetch(32'h1070, 1'b0);
        expect_pred("btb_full_e7", 32'h2070, 1'b0, 1'b1, 4'h0);
        resolve(32'h1080, 32'h2080, 1'b1, 4'h0, 1'b0);
        step(); fetch(32'h1000, 1'b0);
        expect_pred("evicted_e0", 32'h1008, 1'b1, 1'b0, 4'h0);
        step(); fetch(32'h1010, 1'b0);
        expect_pred("kept_e1", 32'h2010, 1'b0, 1'b1, 4'h0);
        resolve(32'h1090, 32'h2090, 1'b1, 4'h0, 1'b0);
        step(); fetch(32'h1010, 1'b0);
        expect_pred("evicted_e1", 32'h1018, 1'b1, 1'b0, 4'h0);
        step(); fetch(32'h1080, 1'b0);
        expect_pred("ninth_hit", 32'h2080, 1'b0, 1'b1, 4'h0);
        step(); fetch(32'h1090, 1'b0);
        expect_pred("tenth_hit", 32'h2090, 1'b0, 1'b1, 4'h0);
        step(); fetch(32'h1020, 1'b0);
        expect_pred("kept_e2", 32'h2020, 1'b0, 1'b1, 4'h0);

        // Speculative history shift and mispredict repair priority
        reset_dut();
        resolve(32'h100, 32'h300, 1'b1, 4'h0, 1'b0); step();
        resolve(32'h100, 32'h300, 1'b1, 4'h1, 1'b0); step();
        resolve(32'h100, 32'h300, 1'b1, 4'h3, 1'b0); step();
        fetch(32'h100, 1'b1);
        expect_pred("hist0", 32'h300, 1'b0, 1'b1, 4'h0);
        step(); fetch(32'h100, 1'b1);
        expect_pred("hist1", 32'h300, 1'b0, 1'b1, 4'h1);
        step(); fetch(32'h100, 1'b1);
        expect_pred("hist3", 32'h300, 1'b0, 1'b1, 4'h3);
        step(); fetch(32'h100, 1'b1);
        resolve(32'h500, 32'h504, 1'b0, 4'h2, 1'b1);
        expect_pred("hist7", 32'h108, 1'b1, 1'b0, 4'h7);
        step(); fetch(32'h108, 1'b1);
        expect_pred("repair_prio", 32'h110, 1'b1, 1'b0, 4'h4);
        step(); fetch(32'h100, 1'b1);
        expect_pred("miss_no_shift", 32'h108, 1'b1, 1'b0, 4'h4);
        step(); fetch(32'h100, 1'b0);
        expect_pred("nt_hit_shift", 32'h108, 1'b1, 1'b0, 4'h8);

        // Counter saturation; not-taken resolves leave the BTB entry alone
        reset_dut();
        fetch(32'h100, 1'b0);
        for (int k = 0; k < 3; k++) begin
            resolve(32'h104, 32'h200, 1'b1, 4'h0, 1'b0);
            step();
        end
        resolve(32'h104, 32'h200, 1'b0, 4'h0, 1'b0);
        step();
        expect_pred("nt1_still_taken", 32'h200, 1'b1, 1'b1, 4'h0);
        resolve(32'h104, 32'h200, 1'b0, 4'h0, 1'b0);
        step();
        expect_pred("nt2_not_taken", 32'h108, 1'b1, 1'b0, 4'h0);
        resolve(32'h104, 32'h200, 1'b0, 4'h0, 1'b0); step();
        resolve(32'h104, 32'h200, 1'b0, 4'h0, 1'b0); step();
        resolve(32'h500, 32'h504, 1'b0, 4'h4, 1'b1); step();
        fetch(32'h100, 1'b1);
        expect_pred("nt_hit_hist8", 32'h108, 1'b1, 1'b0, 4'h8);
        step(); fetch(32'h100, 1'b0);
        expect_pred("btb_kept", 32'h108, 1'b1, 1'b0, 4'h0);
        resolve(32'h104, 32'h200, 1'b1, 4'h0, 1'b0);
        step();
        expect_pred("floor_sat", 32'h108, 1'b1, 1'b0, 4'h0);
        resolve(32'h104, 32'h200, 1'b1, 4'h0, 1'b0);
        step();
        expect_pred("retrained", 32'h200, 1'b1, 1'b1, 4'h0);

        // Statistics saturation and mid-stream reset
        reset_dut();
        fetch(32'h100, 1'b0);
        for (int k = 0; k < 65541; k++) begin
            resolve(32'h700, 32'h704, 1'b0, 4'h0, 1'b1);
            step();
        end
        expect_pred("stat_sat", 32'h108, 1'b1, 1'b0, 4'h0);
        step();
        resolve(32'h700, 32'h704, 1'b0, 4'h0, 1'b1);
        rst = 1'b1;
        expect_pred("stat_in_rst", 32'h108, 1'b1, 1'b0, 4'h0);
        step();
        expect_pred("stat_after_rst", 32'h108, 1'b1, 1'b0, 4'h0);

        // Drain and report
        step();
        step();
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
        if (exp_q.size() > 0) begin
            checks++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
